// File: rtl/btb_update_controller.sv
// btb_update_controller
// Queues resolved-branch updates and issues each one to the BTB as a SETUP/COMMIT
// pair (the BTB latches its write index one cycle before the write lands). Also
// owns BTB flush: queued updates are dropped and every BTB index is invalidated,
// one per cycle.
//
// Handshake: an update transfers on a rising edge where upd_valid && upd_ready.
// upd_valid may be held with stable payload until accepted; upd_ready never
// depends on upd_valid.
module btb_update_controller #(
    parameter int FIFO_DEPTH  = 4,
    parameter int BTB_ENTRIES = 1024,
    parameter int IDX_W       = 10
) (
    input  logic                        btb_ctrl_clk,
    input  logic                        btb_ctrl_reset,
    input  logic                        upd_valid,
    output logic                        upd_ready,
    input  logic [31:0]                 upd_pc,
    input  logic [31:0]                 upd_target,
    input  logic                        upd_taken,
    input  logic                        flush_req,
    output logic                        flush_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [31:0]                 btb_new_pc,
    output logic [31:0]                 btb_data,
    output logic                        btb_branch_taken,
    output logic                        btb_write,
    output logic                        btb_inv,
    output logic [IDX_W-1:0]            btb_inv_index,
    output logic [1:0]                  fsm_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_SWEEP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        mem_pc  [FIFO_DEPTH];
    logic [31:0]        mem_tgt [FIFO_DEPTH];
    logic               mem_tk  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [IDX_W-1:0]   sweep_idx_q;
    logic               push, pop;

    // Accept only when there is room, no sweep runs and no flush is being requested.
    assign upd_ready = (count_q != CNT_W'(FIFO_DEPTH)) && (state_q != ST_SWEEP) && !flush_req;
    assign push      = upd_valid && upd_ready;
    // The head leaves at the closing edge of COMMIT; a flush clears the queue anyway.
    assign pop       = (state_q == ST_COMMIT);

    assign fifo_count = count_q;
    assign fsm_state  = state_q;

    // Next-state logic; a sampled flush_req overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (flush_req) begin
            state_d = ST_SWEEP;
        end else begin
            case (state_q)
                ST_IDLE:   if (count_q != '0) state_d = ST_SETUP;
                ST_SETUP:  state_d = ST_COMMIT;
                ST_COMMIT: state_d = ((count_q > CNT_W'(1)) || push) ? ST_SETUP : ST_IDLE;
                ST_SWEEP:  if (sweep_idx_q == IDX_W'(BTB_ENTRIES - 1)) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // BTB-facing outputs decoded purely from registered state and the FIFO head.
    always_comb begin
        btb_new_pc       = '0;
        btb_data         = '0;
        btb_branch_taken = 1'b0;
        btb_write        = 1'b0;
        btb_inv          = 1'b0;
        btb_inv_index    = '0;
        flush_busy       = 1'b0;
        case (state_q)
            ST_SETUP, ST_COMMIT: begin
                btb_new_pc       = mem_pc[rd_ptr_q];
                btb_data         = mem_tgt[rd_ptr_q];
                btb_branch_taken = mem_tk[rd_ptr_q];
                btb_write        = (state_q == ST_COMMIT);
            end
            ST_SWEEP: begin
                btb_inv       = 1'b1;
                btb_inv_index = sweep_idx_q;
                flush_busy    = 1'b1;
            end
            default: ;
        endcase
    end

    // State register and sweep counter; flush restarts the sweep at index 0.
    always_ff @(posedge btb_ctrl_clk or negedge btb_ctrl_reset) begin
        if (!btb_ctrl_reset) begin
            state_q     <= ST_IDLE;
            sweep_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (flush_req) begin
                sweep_idx_q <= '0;
            end else if (state_q == ST_SWEEP) begin
                sweep_idx_q <= (sweep_idx_q == IDX_W'(BTB_ENTRIES - 1)) ? '0 : sweep_idx_q + 1'b1;
            end else begin
                sweep_idx_q <= '0;
            end
        end
    end

    // FIFO pointers and occupancy; a flush discards everything queued.
    always_ff @(posedge btb_ctrl_clk or negedge btb_ctrl_reset) begin
        if (!btb_ctrl_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_req) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO payload storage; contents are only observed while an entry is valid.
    always_ff @(posedge btb_ctrl_clk) begin
        if (push) begin
            mem_pc[wr_ptr_q]  <= upd_pc;
            mem_tgt[wr_ptr_q] <= upd_target;
            mem_tk[wr_ptr_q]  <= upd_taken;
        end
    end

endmodule

// File: tb/tb_btb_update_controller.sv
// Bench for btb_update_controller: directed scenarios followed by random traffic,
// every output compared each cycle against a queue-based reference model.
module tb_btb_update_controller;

    localparam int FD = 4;
    localparam int NE = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          upd_valid, upd_ready, upd_taken, flush_req, flush_busy;
    logic [31:0]   upd_pc, upd_target;
    logic [2:0]    fifo_count;
    logic [31:0]   btb_new_pc, btb_data;
    logic          btb_branch_taken, btb_write, btb_inv;
    logic [IW-1:0] btb_inv_index;
    logic [1:0]    fsm_state;

    btb_update_controller #(.FIFO_DEPTH(FD), .BTB_ENTRIES(NE), .IDX_W(IW)) dut (
        .btb_ctrl_clk     (clk),
        .btb_ctrl_reset   (rst_n),
        .upd_valid        (upd_valid),
        .upd_ready        (upd_ready),
        .upd_pc           (upd_pc),
        .upd_target       (upd_target),
        .upd_taken        (upd_taken),
        .flush_req        (flush_req),
        .flush_busy       (flush_busy),
        .fifo_count       (fifo_count),
        .btb_new_pc       (btb_new_pc),
        .btb_data         (btb_data),
        .btb_branch_taken (btb_branch_taken),
        .btb_write        (btb_write),
        .btb_inv          (btb_inv),
        .btb_inv_index    (btb_inv_index),
        .fsm_state        (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: queue of pending updates {pc,target,taken}; issue phase
    // 0 = nothing issued, 1 = first cycle of an update, 2 = write cycle;
    // sweep position -1 when no flush sweep is running.
    logic [64:0] m_q[$];
    int          m_phase;
    int          m_sweep;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase = 0;
        m_sweep = -1;
    endtask

    function automatic logic model_ready(input logic fl);
        return (m_q.size() < FD) && (m_sweep < 0) && !fl;
    endfunction

    task automatic check_outputs();
        logic [64:0] head;
        head = (m_phase != 0) ? m_q[0] : 65'd0;
        chk("upd_ready",   32'(upd_ready),        32'(model_ready(flush_req)));
        chk("fifo_count",  32'(fifo_count),       m_q.size());
        chk("btb_new_pc",  btb_new_pc,            head[64:33]);
        chk("btb_data",    btb_data,              head[32:1]);
        chk("btb_taken",   32'(btb_branch_taken), 32'(head[0]));
        chk("btb_write",   32'(btb_write),        32'(m_phase == 2));
        chk("btb_inv",     32'(btb_inv),          32'(m_sweep >= 0));
        chk("flush_busy",  32'(flush_busy),       32'(m_sweep >= 0));
        chk("inv_index",   32'(btb_inv_index),    (m_sweep >= 0) ? m_sweep : 0);
    endtask

    task automatic model_step(input logic v, input logic [31:0] pc, input logic [31:0] tg,
                              input logic tk, input logic fl);
        logic push;
        int   n0;
        push = v && model_ready(fl);
        n0   = m_q.size();
        if (fl) begin
            m_q.delete();
            m_phase = 0;
            m_sweep = 0;
        end else if (m_sweep >= 0) begin
            m_sweep = (m_sweep == NE - 1) ? -1 : m_sweep + 1;
        end else begin
            if (m_phase == 2) void'(m_q.pop_front());
            if (push) m_q.push_back({pc, tg, tk});
            case (m_phase)
                2:       m_phase = (m_q.size() > 0) ? 1 : 0;
                1:       m_phase = 2;
                default: m_phase = (n0 > 0) ? 1 : 0;
            endcase
        end
    endtask

    // Driver: one clock cycle with the given inputs; outputs checked mid-cycle.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] tg,
                         input logic tk, input logic fl, output logic acc);
        @(negedge clk);
        upd_valid  = v;
        upd_pc     = pc;
        upd_target = tg;
        upd_taken  = tk;
        flush_req  = fl;
        #1;
        check_outputs();
        acc = v && model_ready(fl);
        @(posedge clk);
        model_step(v, pc, tg, tk, fl);
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, acc);
    endtask

    task automatic push_update(input logic [31:0] pc, input logic [31:0] tg, input logic tk);
        logic acc;
        int   n;
        n = 0;
        do begin
            cycle(1'b1, pc, tg, tk, 1'b0, acc);
            n++;
        end while (!acc && n < 20);
        chk("accept_within_bound", 32'(acc), 32'd1);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset(input int n);
        @(negedge clk);
        #3;
        rst_n     = 1'b0;
        upd_valid = 1'b0;
        flush_req = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs();
    endtask

    initial begin
        logic acc;
        int   n;
        int   r;
        rst_n      = 1'b0;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_target = '0;
        upd_taken  = 1'b0;
        flush_req  = 1'b0;
        model_reset();
        #2;
        check_outputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Reset at a random cycle, then stay idle with no writes.
        idle($urandom_range(1, 6));
        do_reset(2);
        idle(3);

        // Single update: SETUP, COMMIT, back to IDLE.
        cycle(1'b1, 32'h0000_1004, 32'h0000_2000, 1'b1, 1'b0, acc);
        idle(5);

        // Five back-to-back updates into a depth-4 queue.
        for (int i = 0; i < 5; i++) push_update(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), i[0]);
        idle(12);

        // Flush while in SETUP with three entries queued.
        n = 0;
        while (!(m_phase == 1 && m_q.size() == 3) && n < 20) begin
            cycle(1'b1, 32'h400 + 32'(4 * n), 32'h4000 + 32'(n), 1'b1, 1'b0, acc);
            n++;
        end
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
        idle(NE + 3);

        // Flush in the COMMIT cycle of 0x200 with a competing push, then re-flush at index 9.
        cycle(1'b1, 32'h200, 32'h2200, 1'b0, 1'b0, acc);
        n = 0;
        while (m_phase != 2 && n < 10) begin
            idle(1);
            n++;
        end
        cycle(1'b1, 32'h300, 32'h3300, 1'b1, 1'b1, acc);
        n = 0;
        while (m_sweep != 9 && n < 20) begin
            idle(1);
            n++;
        end
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
        idle(NE + 3);

        // Async reset at sweep index 7, then a normal update.
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
        n = 0;
        while (m_sweep != 7 && n < 20) begin
            idle(1);
            n++;
        end
        do_reset(2);
        cycle(1'b1, 32'h0000_1004, 32'h0000_2000, 1'b1, 1'b0, acc);
        idle(5);

        // Random traffic with occasional flushes and resets.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                cycle(r < 130, $urandom, $urandom, 1'($urandom_range(0, 1)), r >= 195, acc);
            end
        end
        idle(NE + 4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
